// File: rtl/rf_arb_pkg.sv
// Shared types and constants for the register-file write arbiter.
package rf_arb_pkg;

    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned REG_AW   = $clog2(NUM_REGS);
    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [31:0]       data;
    } rf_wr_t;

    typedef logic [NUM_REGS-1:0] sb_vec_t;

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Bus bundle between the pipeline (master) and the register-file write arbiter (slave).
interface rf_write_arbiter_if
    import rf_arb_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

    logic              wb_we;
    logic [REG_AW-1:0] wb_addr;
    logic [31:0]       wb_data;
    logic              mdu_valid;
    logic              mdu_ready;
    logic [REG_AW-1:0] mdu_addr;
    logic [31:0]       mdu_data;
    logic              issue_valid;
    logic [REG_AW-1:0] issue_addr;
    logic [REG_AW-1:0] rs_addr;
    logic [REG_AW-1:0] rt_addr;
    logic [REG_AW-1:0] rd_addr;
    logic              rs_busy;
    logic              rt_busy;
    logic              rd_busy;
    logic              rf_we;
    logic [REG_AW-1:0] rf_waddr;
    logic [31:0]       rf_wdata;
    logic              starve_hold;
    logic [CntW-1:0]   fifo_count;

    modport master (
        output wb_we, wb_addr, wb_data, mdu_valid, mdu_addr, mdu_data,
               issue_valid, issue_addr, rs_addr, rt_addr, rd_addr,
        input  mdu_ready, rs_busy, rt_busy, rd_busy, rf_we, rf_waddr, rf_wdata,
               starve_hold, fifo_count
    );

    modport slave (
        input  wb_we, wb_addr, wb_data, mdu_valid, mdu_addr, mdu_data,
               issue_valid, issue_addr, rs_addr, rt_addr, rd_addr,
        output mdu_ready, rs_busy, rt_busy, rd_busy, rf_we, rf_waddr, rf_wdata,
               starve_hold, fifo_count
    );

endinterface

// File: rtl/rf_wb_fifo.sv
// Synchronous FIFO of pending MDU register writes; Depth must be a power of two.
module rf_wb_fifo
    import rf_arb_pkg::*;
#(
    parameter int unsigned Depth = 4,
    localparam int unsigned PtrW = $clog2(Depth),
    localparam int unsigned CntW = PtrW + 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            push_i,
    input  rf_wr_t          wdata_i,
    input  logic            pop_i,
    output rf_wr_t          rdata_o,
    output logic            full_o,
    output logic            empty_o,
    output logic [CntW-1:0] count_o
);

    rf_wr_t          mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q, count_d;
    logic            do_push, do_pop;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        count_d = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            count_q <= count_d;
        end
    end

    // Storage needs no reset: entries are only read when count says they are valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: WB has priority, MDU results queue and drain into idle slots.
// Optional same-cycle MDU bypass when idle is enabled by defining RF_ARB_BYPASS_EN.
module rf_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input logic               clk_i,
    input logic               rst_ni,
    rf_write_arbiter_if.slave bus
);

    localparam int unsigned CntW    = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);

    logic               wb_own, mdu_acc, push, pop, byp, mdu_commit;
    logic               fifo_full, fifo_empty, port_we;
    logic [CntW-1:0]    count;
    rf_wr_t             head, mdu_wr, port_wr;
    sb_vec_t            sb_q, sb_d;
    logic [StarveW-1:0] starve_q, starve_d;

    assign wb_own  = bus.wb_we && (bus.wb_addr != REG_ZERO);
    assign mdu_acc = bus.mdu_valid && !fifo_full;
    assign mdu_wr  = '{addr: bus.mdu_addr, data: bus.mdu_data};

`ifdef RF_ARB_BYPASS_EN
    assign byp = mdu_acc && fifo_empty && !wb_own && (bus.mdu_addr != REG_ZERO);
`else
    assign byp = 1'b0;
`endif

    // r0 results are accepted but never queued.
    assign push       = mdu_acc && (bus.mdu_addr != REG_ZERO) && !byp;
    assign pop        = !wb_own && !fifo_empty;
    assign mdu_commit = pop || byp;

    rf_wb_fifo #(
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .wdata_i (mdu_wr),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (count)
    );

    always_comb begin
        port_we = 1'b0;
        port_wr = '0;
        if (wb_own) begin
            port_we = 1'b1;
            port_wr = '{addr: bus.wb_addr, data: bus.wb_data};
        end else if (!fifo_empty) begin
            port_we = 1'b1;
            port_wr = head;
        end else if (byp) begin
            port_we = 1'b1;
            port_wr = mdu_wr;
        end
    end

    // Port is forced quiet while reset is held, even if WB is still driving.
    assign bus.rf_we    = rst_ni && port_we;
    assign bus.rf_waddr = rst_ni ? port_wr.addr : '0;
    assign bus.rf_wdata = rst_ni ? port_wr.data : '0;

    always_comb begin
        sb_d = sb_q;
        if (mdu_commit) sb_d[port_wr.addr] = 1'b0;
        // Applied after the clear so a same-register issue wins.
        if (bus.issue_valid && (bus.issue_addr != REG_ZERO)) sb_d[bus.issue_addr] = 1'b1;
    end

    always_comb begin
        starve_d = starve_q;
        if (fifo_empty || pop) begin
            starve_d = '0;
        end else if (wb_own && (starve_q != '1)) begin
            starve_d = starve_q + StarveW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sb_q     <= '0;
            starve_q <= '0;
        end else begin
            sb_q     <= sb_d;
            starve_q <= starve_d;
        end
    end

    assign bus.rs_busy     = sb_q[bus.rs_addr];
    assign bus.rt_busy     = sb_q[bus.rt_addr];
    assign bus.rd_busy     = sb_q[bus.rd_addr];
    assign bus.mdu_ready   = !fifo_full;
    assign bus.fifo_count  = count;
    assign bus.starve_hold = (starve_q >= StarveW'(STARVE_LIMIT));

`ifndef SYNTHESIS
    // Decode must stall on rd_busy before issuing to an already-busy destination.
    a_issue_not_busy: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (bus.issue_valid && (bus.issue_addr != REG_ZERO)) |-> !sb_q[bus.issue_addr]);
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed self-checking bench for rf_write_arbiter.
module tb_rf_write_arbiter;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    rf_write_arbiter_if #(.FIFO_DEPTH(4)) bus ();

    rf_write_arbiter #(
        .FIFO_DEPTH   (4),
        .STARVE_LIMIT (8)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wb_we = 0; bus.wb_addr = 0; bus.wb_data = 0;
        bus.mdu_valid = 0; bus.mdu_addr = 0; bus.mdu_data = 0;
        bus.issue_valid = 0; bus.issue_addr = 0;
        bus.rs_addr = 0; bus.rt_addr = 0; bus.rd_addr = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle();
        #1;
        checks++; if (bus.rf_we !== 1'b0) begin failures++; $display("FAIL por_rf_we got=%0h exp=0", bus.rf_we); end
        checks++; if (bus.rf_waddr !== 5'd0) begin failures++; $display("FAIL por_rf_waddr got=%0h exp=0", bus.rf_waddr); end
        checks++; if (bus.rf_wdata !== 32'd0) begin failures++; $display("FAIL por_rf_wdata got=%0h exp=0", bus.rf_wdata); end
        checks++; if (bus.mdu_ready !== 1'b1) begin failures++; $display("FAIL por_mdu_ready got=%0h exp=1", bus.mdu_ready); end
        checks++; if (bus.starve_hold !== 1'b0) begin failures++; $display("FAIL por_starve got=%0h exp=0", bus.starve_hold); end
        repeat (2) step();
        rst_n = 1;
        step();
        for (int i = 0; i < 3; i++) begin
            bus.wb_we = 1; bus.wb_addr = 5'd1; bus.wb_data = 32'd1;
            bus.mdu_valid = 1; bus.mdu_addr = 5'(10 + i); bus.mdu_data = 32'hA0 + i;
            bus.issue_valid = 1; bus.issue_addr = 5'(10 + i);
            step();
        end
        bus.mdu_valid = 0; bus.issue_valid = 0;
        bus.rs_addr = 5'd10; bus.rt_addr = 5'd11; bus.rd_addr = 5'd12;
        #1;
        checks++; if (bus.fifo_count !== 3'd3) begin failures++; $display("FAIL pre_rst_count got=%0d exp=3", bus.fifo_count); end
        checks++; if (bus.rs_busy !== 1'b1) begin failures++; $display("FAIL pre_rst_rs_busy got=%0h exp=1", bus.rs_busy); end
        rst_n = 0;
        #1;
        checks++; if (bus.rf_we !== 1'b0) begin failures++; $display("FAIL rst_rf_we got=%0h exp=0", bus.rf_we); end
        checks++; if (bus.fifo_count !== 3'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", bus.fifo_count); end
        checks++; if ({bus.rs_busy, bus.rt_busy, bus.rd_busy} !== 3'b000) begin failures++; $display("FAIL rst_busy got=%b exp=000", {bus.rs_busy, bus.rt_busy, bus.rd_busy}); end
        checks++; if (bus.mdu_ready !== 1'b1) begin failures++; $display("FAIL rst_mdu_ready got=%0h exp=1", bus.mdu_ready); end
        idle();
        step();
        rst_n = 1;
        step();
    endtask

    task automatic test_wb_basic();
        bus.wb_we = 1; bus.wb_addr = 5'd5; bus.wb_data = 32'h1234;
        #1;
        checks++; if (bus.rf_we !== 1'b1) begin failures++; $display("FAIL wb_rf_we got=%0h exp=1", bus.rf_we); end
        checks++; if (bus.rf_waddr !== 5'd5) begin failures++; $display("FAIL wb_waddr got=%0d exp=5", bus.rf_waddr); end
        checks++; if (bus.rf_wdata !== 32'h1234) begin failures++; $display("FAIL wb_wdata got=%0h exp=1234", bus.rf_wdata); end
        step();
        bus.wb_addr = 5'd0; bus.wb_data = 32'h55;
        #1;
        checks++; if (bus.rf_we !== 1'b0) begin failures++; $display("FAIL wb_r0_rf_we got=%0h exp=0", bus.rf_we); end
        idle();
        step();
    endtask

    task automatic test_mdu_queue();
        bus.issue_valid = 1; bus.issue_addr = 5'd7;
        step();
        bus.issue_valid = 0; bus.rs_addr = 5'd7;
        bus.wb_we = 1; bus.wb_addr = 5'd3; bus.wb_data = 32'h33;
        bus.mdu_valid = 1; bus.mdu_addr = 5'd7; bus.mdu_data = 32'hBEEF;
        #1;
        checks++; if (bus.rs_busy !== 1'b1) begin failures++; $display("FAIL q_rs_busy_issue got=%0h exp=1", bus.rs_busy); end
        checks++; if (bus.rf_waddr !== 5'd3 || bus.rf_we !== 1'b1) begin failures++; $display("FAIL q_wb_first got=%0d exp=3", bus.rf_waddr); end
        step();
        bus.wb_we = 0; bus.mdu_valid = 0;
        #1;
        checks++; if (bus.fifo_count !== 3'd1) begin failures++; $display("FAIL q_count got=%0d exp=1", bus.fifo_count); end
        checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd7) begin failures++; $display("FAIL q_commit_addr got=%0d exp=7", bus.rf_waddr); end
        checks++; if (bus.rf_wdata !== 32'hBEEF) begin failures++; $display("FAIL q_commit_data got=%0h exp=beef", bus.rf_wdata); end
        checks++; if (bus.rs_busy !== 1'b1) begin failures++; $display("FAIL q_busy_commit got=%0h exp=1", bus.rs_busy); end
        step();
        checks++; if (bus.rs_busy !== 1'b0) begin failures++; $display("FAIL q_busy_after got=%0h exp=0", bus.rs_busy); end
        checks++; if (bus.fifo_count !== 3'd0 || bus.rf_we !== 1'b0) begin failures++; $display("FAIL q_drained got=%0d exp=0", bus.fifo_count); end
        idle();
        step();
    endtask

    task automatic test_starve();
        for (int c = 0; c < 10; c++) begin
            bus.wb_we = 1; bus.wb_addr = 5'd2; bus.wb_data = 32'(c);
            bus.mdu_valid = (c < 4); bus.mdu_addr = 5'(20 + c); bus.mdu_data = 32'h200 + 32'(c);
            #1;
            if (c < 4) begin
                checks++; if (bus.mdu_ready !== 1'b1) begin failures++; $display("FAIL st_ready_c%0d got=%0h exp=1", c, bus.mdu_ready); end
            end
            if (c == 4) begin
                checks++; if (bus.mdu_ready !== 1'b0 || bus.fifo_count !== 3'd4) begin failures++; $display("FAIL st_full got=%0h/%0d exp=0/4", bus.mdu_ready, bus.fifo_count); end
            end
            if (c == 8) begin
                checks++; if (bus.starve_hold !== 1'b0) begin failures++; $display("FAIL st_hold_7 got=%0h exp=0", bus.starve_hold); end
            end
            if (c == 9) begin
                checks++; if (bus.starve_hold !== 1'b1) begin failures++; $display("FAIL st_hold_8 got=%0h exp=1", bus.starve_hold); end
            end
            step();
        end
        bus.wb_we = 0; bus.mdu_valid = 0;
        #1;
        checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd20 || bus.rf_wdata !== 32'h200) begin failures++; $display("FAIL st_bubble_pop got=%0d/%0h exp=20/200", bus.rf_waddr, bus.rf_wdata); end
        step();
        bus.wb_we = 1;
        #1;
        checks++; if (bus.starve_hold !== 1'b0) begin failures++; $display("FAIL st_hold_clr got=%0h exp=0", bus.starve_hold); end
        checks++; if (bus.fifo_count !== 3'd3) begin failures++; $display("FAIL st_count3 got=%0d exp=3", bus.fifo_count); end
        step();
        idle();
        repeat (3) step();
        checks++; if (bus.fifo_count !== 3'd0) begin failures++; $display("FAIL st_drain got=%0d exp=0", bus.fifo_count); end
    endtask

    task automatic test_full_order();
        int idx;
        for (int i = 0; i < 4; i++) begin
            bus.wb_we = 1; bus.wb_addr = 5'd1; bus.wb_data = 32'd0;
            bus.mdu_valid = 1; bus.mdu_addr = 5'(24 + i); bus.mdu_data = 32'h100 + 32'(24 + i);
            step();
        end
        bus.wb_we = 0;
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            bus.mdu_valid = (idx < 4);
            bus.mdu_addr = 5'(28 + idx); bus.mdu_data = 32'h100 + 32'(28 + idx);
            #1;
            checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'(24 + c) || bus.rf_wdata !== 32'h100 + 32'(24 + c)) begin
                failures++; $display("FAIL fo_order_c%0d got=%0d/%0h exp=%0d/%0h", c, bus.rf_waddr, bus.rf_wdata, 24 + c, 32'h100 + 32'(24 + c));
            end
            if (c < 5) begin
                checks++; if (bus.mdu_ready !== (c != 0)) begin failures++; $display("FAIL fo_ready_c%0d got=%0h exp=%0h", c, bus.mdu_ready, (c != 0)); end
            end
            if (bus.mdu_valid && bus.mdu_ready) idx++;
            step();
        end
        idle();
        #1;
        checks++; if (bus.fifo_count !== 3'd0) begin failures++; $display("FAIL fo_empty got=%0d exp=0", bus.fifo_count); end
        step();
    endtask

    task automatic test_bypass();
        bus.mdu_valid = 1; bus.mdu_addr = 5'd0; bus.mdu_data = 32'hDEAD;
        step();
        bus.mdu_valid = 0;
        #1;
        checks++; if (bus.fifo_count !== 3'd0 || bus.rf_we !== 1'b0) begin failures++; $display("FAIL bp_r0_drop got=%0d/%0h exp=0/0", bus.fifo_count, bus.rf_we); end
        bus.issue_valid = 1; bus.issue_addr = 5'd9;
        step();
        bus.issue_valid = 0; bus.rs_addr = 5'd9;
        bus.mdu_valid = 1; bus.mdu_addr = 5'd9; bus.mdu_data = 32'h99;
        #1;
`ifdef RF_ARB_BYPASS_EN
        checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd9 || bus.rf_wdata !== 32'h99) begin failures++; $display("FAIL bp_same_cycle got=%0h/%0d exp=1/9", bus.rf_we, bus.rf_waddr); end
        step();
        bus.mdu_valid = 0;
        #1;
        checks++; if (bus.fifo_count !== 3'd0) begin failures++; $display("FAIL bp_count got=%0d exp=0", bus.fifo_count); end
        checks++; if (bus.rs_busy !== 1'b0) begin failures++; $display("FAIL bp_busy got=%0h exp=0", bus.rs_busy); end
`else
        checks++; if (bus.rf_we !== 1'b0) begin failures++; $display("FAIL nb_no_bypass got=%0h exp=0", bus.rf_we); end
        step();
        bus.mdu_valid = 0;
        #1;
        checks++; if (bus.fifo_count !== 3'd1 || bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd9) begin failures++; $display("FAIL nb_next_cycle got=%0d/%0d exp=1/9", bus.fifo_count, bus.rf_waddr); end
        step();
        checks++; if (bus.rs_busy !== 1'b0 || bus.fifo_count !== 3'd0) begin failures++; $display("FAIL nb_busy got=%0h exp=0", bus.rs_busy); end
`endif
        idle();
        step();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_wb_basic();
        test_mdu_queue();
        test_starve();
        test_full_order();
        test_bypass();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
